// File: rtl/mont_result_corrector_if.sv
// Bus bundle for mont_result_corrector.
// Carries the start/flag/busy/done control handshake and the three memory
// ports (result-memory read, modulus-memory read, destination write).
//   slave  : the corrector itself (drives busy/done, read requests, writes)
//   master : the requester plus the memories (drives start, flag, read data)
interface mont_result_corrector_if #(
  parameter int RADIX      = 32,
  parameter int WIDTH_REAL = 14
);
  localparam int RES_DEPTH = (WIDTH_REAL + 1) / 2;
  localparam int RES_AW    = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int OUT_AW    = (WIDTH_REAL > 1) ? $clog2(WIDTH_REAL) : 1;

  logic                   start;
  logic                   negative_res_need_correction;
  logic                   busy;
  logic                   done;
  logic                   mult_mem_res_rd_en;
  logic [RES_AW-1:0]      mult_mem_res_rd_addr;
  logic [2*RADIX-1:0]     mult_mem_res_dout;
  logic                   mem_p_rd_en;
  logic [OUT_AW-1:0]      mem_p_rd_addr;
  logic [RADIX-1:0]       mem_p_dout;
  logic                   out_wr_en;
  logic [OUT_AW-1:0]      out_wr_addr;
  logic [RADIX-1:0]       out_din;

  modport slave (
    input  start, negative_res_need_correction, mult_mem_res_dout, mem_p_dout,
    output busy, done, mult_mem_res_rd_en, mult_mem_res_rd_addr,
           mem_p_rd_en, mem_p_rd_addr, out_wr_en, out_wr_addr, out_din
  );

  modport master (
    output start, negative_res_need_correction, mult_mem_res_dout, mem_p_dout,
    input  busy, done, mult_mem_res_rd_en, mult_mem_res_rd_addr,
           mem_p_rd_en, mem_p_rd_addr, out_wr_en, out_wr_addr, out_din
  );
endinterface

// File: rtl/mont_result_corrector.sv
// Montgomery result corrector.
// Streams the multiplier result t (two words per memory entry) and, when the
// latched correction flag is set, the modulus p, and writes
// out = t + (corr ? p : 0) mod 2^(RADIX*WIDTH_REAL) one word per cycle,
// least significant word first.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mont_result_corrector_if.slave (start/flag/busy/done and the
//          result-read, modulus-read and destination-write memory ports)
module mont_result_corrector #(
  parameter int RADIX      = 32,
  parameter int WIDTH_REAL = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  mont_result_corrector_if.slave  bus
);
  localparam int RES_DEPTH = (WIDTH_REAL + 1) / 2;
  localparam int RES_AW    = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int OUT_AW    = (WIDTH_REAL > 1) ? $clog2(WIDTH_REAL) : 1;
  localparam logic [OUT_AW-1:0] LAST = OUT_AW'(WIDTH_REAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state, state_next;
  logic [OUT_AW-1:0] j;        // word index of the read being issued
  logic [OUT_AW-1:0] j_d;      // word index whose read data is arriving
  logic              val_d;    // read data for word j_d is valid this cycle
  logic              corr;
  logic              carry;
  logic              run;
  logic [RADIX-1:0]  t_word;
  logic [RADIX-1:0]  p_word;
  logic [RADIX:0]    sum;

  assign run = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FLUSH waits for the registered write of the last word to be on the port,
  // so DONE lands exactly one cycle after the final write.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (j == LAST) state_next = FLUSH;
      FLUSH:   if (bus.out_wr_en && bus.out_wr_addr == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Even words sit in the upper half of an entry, odd words in the lower half.
  // For odd WIDTH_REAL the final j is even, so the lower half of the last
  // entry is never selected.
  assign t_word = j_d[0] ? bus.mult_mem_res_dout[RADIX-1:0]
                         : bus.mult_mem_res_dout[2*RADIX-1:RADIX];
  assign p_word = corr ? bus.mem_p_dout : '0;
  assign sum    = {1'b0, t_word} + {1'b0, p_word} + {{RADIX{1'b0}}, carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      j               <= '0;
      j_d             <= '0;
      val_d           <= 1'b0;
      corr            <= 1'b0;
      carry           <= 1'b0;
      bus.out_wr_en   <= 1'b0;
      bus.out_wr_addr <= '0;
      bus.out_din     <= '0;
    end else begin
      val_d         <= run;
      j_d           <= j;
      bus.out_wr_en <= val_d;
      if (val_d) begin
        bus.out_wr_addr <= j_d;
        bus.out_din     <= sum[RADIX-1:0];
        carry           <= sum[RADIX];
      end
      if (state == IDLE && bus.start) begin
        j     <= '0;
        corr  <= bus.negative_res_need_correction;
        carry <= 1'b0;
      end else if (run && j != LAST) begin
        j <= j + 1'b1;
      end
    end
  end

  assign bus.busy                 = run || (state == FLUSH);
  assign bus.done                 = (state == DONE);
  assign bus.mult_mem_res_rd_en   = run;
  assign bus.mult_mem_res_rd_addr = run ? RES_AW'(j >> 1) : '0;
  assign bus.mem_p_rd_en          = run && corr;
  assign bus.mem_p_rd_addr        = (run && corr) ? j : '0;
endmodule

// File: tb/tb_mont_result_corrector.sv
// Scoreboard bench for mont_result_corrector with an even (4) and an odd (3)
// word count. Stimulus pushes expected writes/timing into queues; a single
// negedge monitor pops and compares.
module tb_mont_result_corrector;
  localparam time PER = 10;

  typedef struct { time t; int addr; logic [31:0] data; } wexp_t;
  typedef struct { time st; time et; bit corr; bit aborted; } pexp_t;

  logic clk = 1'b0;
  logic rst4, rst3;
  logic [31:0] tw [2][4];
  logic [31:0] pw [2][4];
  logic [31:0] junk [2];
  wexp_t wq [2][$];
  pexp_t pq [2][$];
  logic  rs [2];
  bit    stim_done = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  always #(PER/2) clk = ~clk;

  mont_result_corrector_if #(.RADIX(32), .WIDTH_REAL(4)) bus4 ();
  mont_result_corrector_if #(.RADIX(32), .WIDTH_REAL(3)) bus3 ();

  mont_result_corrector #(.RADIX(32), .WIDTH_REAL(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
  mont_result_corrector #(.RADIX(32), .WIDTH_REAL(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

  // Memory models: one-cycle read latency, garbage when not enabled.
  always @(posedge clk) begin
    int a;
    a = int'(bus4.mult_mem_res_rd_addr);
    if (bus4.mult_mem_res_rd_en) bus4.mult_mem_res_dout <= {tw[0][2*a], tw[0][2*a+1]};
    else                         bus4.mult_mem_res_dout <= {$urandom, $urandom};
    if (bus4.mem_p_rd_en) bus4.mem_p_dout <= pw[0][int'(bus4.mem_p_rd_addr)];
    else                  bus4.mem_p_dout <= $urandom;
    a = int'(bus3.mult_mem_res_rd_addr);
    if (bus3.mult_mem_res_rd_en)
      bus3.mult_mem_res_dout <= {tw[1][2*a], (2*a+1 < 3) ? tw[1][2*a+1] : junk[1]};
    else
      bus3.mult_mem_res_dout <= {$urandom, $urandom};
    if (bus3.mem_p_rd_en) bus3.mem_p_dout <= pw[1][int'(bus3.mem_p_rd_addr)];
    else                  bus3.mem_p_dout <= $urandom;
    rs[0] <= rst4;
    rs[1] <= rst3;
  end

  // ---------------- checking ----------------
  task automatic chk(int g, string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cfg%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  task automatic mon(int g, logic r, logic busy, logic done, logic wr, logic [31:0] waddr,
                     logic [31:0] din, logic mrd, logic [31:0] maddr, logic prd,
                     logic [31:0] paddr);
    time   now = $time;
    bit    act;
    bit    have;
    wexp_t e;
    if (r)
      chk(g, "reset_state", {busy, done, wr, mrd, prd, waddr != 0, maddr != 0,
                             paddr != 0, din != 0}, '0);
    have = pq[g].size() > 0;
    act  = have && now > pq[g][0].st && now < pq[g][0].et;
    chk(g, "busy", busy, act);
    chk(g, "done", done, have && !pq[g][0].aborted && now == pq[g][0].et);
    if (act && !pq[g][0].corr) chk(g, "p_rd_en_without_corr", prd, 0);
    if (wr === 1'b1) begin
      if (wq[g].size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write cfg%0d: got addr %0h data %0h expected none at %0t",
                 g, waddr, din, now);
      end else begin
        e = wq[g].pop_front();
        chk(g, "wr_addr", waddr, e.addr);
        chk(g, "wr_data", din, e.data);
        chk(g, "wr_time", now, e.t);
      end
    end
    while (wq[g].size() > 0 && wq[g][0].t < now) begin
      e = wq[g].pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_write cfg%0d: got none expected addr %0h data %0h at %0t",
               g, e.addr, e.data, e.t);
    end
    if (have && now >= pq[g][0].et) void'(pq[g].pop_front());
  endtask

  always @(negedge clk) begin
    if (!stim_done) begin
      mon(0, rs[0], bus4.busy, bus4.done, bus4.out_wr_en, 32'(bus4.out_wr_addr), bus4.out_din,
          bus4.mult_mem_res_rd_en, 32'(bus4.mult_mem_res_rd_addr), bus4.mem_p_rd_en,
          32'(bus4.mem_p_rd_addr));
      mon(1, rs[1], bus3.busy, bus3.done, bus3.out_wr_en, 32'(bus3.out_wr_addr), bus3.out_din,
          bus3.mult_mem_res_rd_en, 32'(bus3.mult_mem_res_rd_addr), bus3.mem_p_rd_en,
          32'(bus3.mem_p_rd_addr));
    end else begin
      for (int g = 0; g < 2; g++) begin
        chk(g, "leftover_writes", wq[g].size(), 0);
        chk(g, "leftover_passes", pq[g].size(), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  function automatic int wc(int g);
    return (g == 0) ? 4 : 3;
  endfunction

  task automatic set_start(int g, logic s, logic c);
    if (g == 0) begin bus4.start = s; bus4.negative_res_need_correction = c; end
    else        begin bus3.start = s; bus3.negative_res_need_correction = c; end
  endtask

  task automatic set_rst(int g, logic v);
    if (g == 0) rst4 = v;
    else        rst3 = v;
  endtask

  task automatic load(int g, logic [31:0] t0, t1, t2, t3, p0, p1, p2, p3, logic [31:0] jk);
    tw[g][0] = t0; tw[g][1] = t1; tw[g][2] = t2; tw[g][3] = t3;
    pw[g][0] = p0; pw[g][1] = p1; pw[g][2] = p2; pw[g][3] = p3;
    junk[g]  = jk;
  endtask

  function automatic logic [31:0] rword();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference: out = (T + corr*P) mod 2^(32*w) on whole integers; timing taken
  // from the accepting edge.
  task automatic push_exp(int g, bit corr);
    int           w  = wc(g);
    logic [127:0] tv = '0;
    logic [127:0] pv = '0;
    logic [127:0] ev;
    time          t0 = $time;
    wexp_t        e;
    pexp_t        p;
    for (int i = 0; i < w; i++) begin
      tv[32*i +: 32] = tw[g][i];
      pv[32*i +: 32] = pw[g][i];
    end
    ev = tv + (corr ? pv : 128'd0);
    for (int i = 0; i < w; i++) begin
      e.t = t0 + (i + 2) * PER + PER/2;
      e.addr = i;
      e.data = ev[32*i +: 32];
      wq[g].push_back(e);
    end
    p.st = t0;
    p.et = t0 + (w + 2) * PER + PER/2;
    p.corr = corr;
    p.aborted = 1'b0;
    pq[g].push_back(p);
  endtask

  // Entered and left at posedge+1; next start is sampled the cycle after done.
  task automatic run_pass(int g, bit corr, bit poke);
    int w = wc(g);
    set_start(g, 1'b1, corr);
    @(posedge clk);
    push_exp(g, corr);
    #1 set_start(g, 1'b0, !corr);
    if (poke) begin
      repeat (2) @(posedge clk);
      #1 set_start(g, 1'b1, !corr);
      @(posedge clk);
      #1 set_start(g, 1'b0, corr);
      repeat (w) @(posedge clk);
    end else begin
      repeat (w + 3) @(posedge clk);
    end
    #1;
  endtask

  // rst sampled at cycle 4 of the pass.
  task automatic abort_pass(int g, bit corr);
    pexp_t p;
    set_start(g, 1'b1, corr);
    @(posedge clk);
    push_exp(g, corr);
    #1 set_start(g, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 set_rst(g, 1'b1);
    while (wq[g].size() > 0 && wq[g][wq[g].size()-1].t > $time + 4) void'(wq[g].pop_back());
    p = pq[g].pop_back();
    p.aborted = 1'b1;
    p.et = $time + 5;
    pq[g].push_back(p);
    @(posedge clk);
    #1 set_rst(g, 1'b0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic rst_with_start(int g);
    set_rst(g, 1'b1);
    set_start(g, 1'b1, 1'b1);
    @(posedge clk);
    #1 set_rst(g, 1'b0);
    set_start(g, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    set_start(0, 1'b0, 1'b0);
    set_start(1, 1'b0, 1'b0);
    load(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    load(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst4 = 1'b0;
    rst3 = 1'b0;
    @(posedge clk);
    #1;

    // Four-word instance: directed cases.
    load(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, 0);
    run_pass(0, 1'b1, 1'b0);
    load(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 5, 5, 5, 5, 0);
    run_pass(0, 1'b0, 1'b0);
    load(0, '1, '1, '1, '1, 1, 0, 0, 0, 0);
    run_pass(0, 1'b1, 1'b0);
    load(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, 0);
    abort_pass(0, 1'b1);
    run_pass(0, 1'b1, 1'b0);
    run_pass(0, 1'b1, 1'b0);
    run_pass(0, 1'b1, 1'b1);
    run_pass(0, 1'b1, 1'b0);
    rst_with_start(0);
    for (int n = 0; n < 20; n++) begin
      load(0, rword(), rword(), rword(), rword(), rword(), rword(), rword(), rword(), 0);
      run_pass(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Three-word instance: odd count, junk lower half of the last entry.
    load(1, 32'h1, 32'h2, 32'h3, 0, 32'h10, 32'h20, 32'h30, 0, 32'hDEAD_BEEF);
    run_pass(1, 1'b1, 1'b0);
    run_pass(1, 1'b0, 1'b0);
    abort_pass(1, 1'b1);
    run_pass(1, 1'b1, 1'b1);
    rst_with_start(1);
    for (int n = 0; n < 20; n++) begin
      load(1, rword(), rword(), rword(), 0, rword(), rword(), rword(), 0, $urandom);
      run_pass(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1 stim_done = 1'b1;
  end
endmodule
